counter_bank: RTL and testbench

//   Bank of NUM_CH independent up/down counters. Each channel adds a valid-qualified

---
 rtl/counter_bank.sv | 148 ++++++++++++++
 tb/tb_counter_bank.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : counter_bank
// Description : Bank of NUM_CH independent up/down counters sharing one clock.
//               Each channel adds a valid-qualified increment and subtracts a
//               valid-qualified decrement in the same cycle. An optional reinit
//               replaces the current count as the base for that cycle. Each
//               channel either wraps modulo MAX_VALUE+1 or saturates to
//               [0, MAX_VALUE]. Sticky overflow/underflow flags are kept per
//               channel and can be cleared.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1               clock, rising edge
//   rst_n          in   1               asynchronous active-low reset
//   sat_mode       in   NUM_CH          1 = saturate, 0 = wrap modulo MAX_VALUE+1
//   reinit         in   NUM_CH          use initial_value as base this cycle
//   initial_value  in   NUM_CH*WIDTH    reinit base, ch i at [i*WIDTH +: WIDTH]
//   incr_valid     in   NUM_CH          qualifies incr
//   incr           in   NUM_CH*STEP_W   unsigned increment, ch i at [i*STEP_W +: STEP_W]
//   decr_valid     in   NUM_CH          qualifies decr
//   decr           in   NUM_CH*STEP_W   unsigned decrement
//   clr_flags      in   NUM_CH          clears the sticky flags of a channel
//   value          out  NUM_CH*WIDTH    registered count
//   value_next     out  NUM_CH*WIDTH    count that value takes at the next edge
//   at_zero        out  NUM_CH          value == 0
//   at_max         out  NUM_CH          value == MAX_VALUE
//   ovf_sticky     out  NUM_CH          an enabled update exceeded MAX_VALUE
//   udf_sticky     out  NUM_CH          an enabled update went below zero
// ============================================================================
module counter_bank #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 8,
    parameter int STEP_W      = 2,
    parameter int MAX_VALUE   = (2 ** WIDTH) - 1,
    parameter int RESET_VALUE = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        sat_mode,
    input  logic [NUM_CH-1:0]        reinit,
    input  logic [NUM_CH*WIDTH-1:0]  initial_value,
    input  logic [NUM_CH-1:0]        incr_valid,
    input  logic [NUM_CH*STEP_W-1:0] incr,
    input  logic [NUM_CH-1:0]        decr_valid,
    input  logic [NUM_CH*STEP_W-1:0] decr,
    input  logic [NUM_CH-1:0]        clr_flags,
    output logic [NUM_CH*WIDTH-1:0]  value,
    output logic [NUM_CH*WIDTH-1:0]  value_next,
    output logic [NUM_CH-1:0]        at_zero,
    output logic [NUM_CH-1:0]        at_max,
    output logic [NUM_CH-1:0]        ovf_sticky,
    output logic [NUM_CH-1:0]        udf_sticky
);

    // Two guard bits above WIDTH: one holds the carry of base + inc, the
    // other is the sign so that base - dec below zero is representable.
    localparam int c_raw_w = WIDTH + 2;

    localparam logic [WIDTH-1:0]          c_max_w   = WIDTH'(MAX_VALUE);
    localparam logic [WIDTH-1:0]          c_reset_w = WIDTH'(RESET_VALUE);
    localparam logic signed [c_raw_w-1:0] c_max_raw = c_raw_w'(MAX_VALUE);
    localparam logic signed [c_raw_w-1:0] c_mod_raw = c_raw_w'(MAX_VALUE + 1);
    localparam logic [c_raw_w-STEP_W-1:0] c_step_pad = '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0]          w_base;
        logic [STEP_W-1:0]         w_inc;
        logic [STEP_W-1:0]         w_dec;
        logic signed [c_raw_w-1:0] w_raw;
        logic signed [c_raw_w-1:0] w_sel;
        logic                      w_ovf;
        logic                      w_udf;
        logic                      w_en;
        logic [WIDTH-1:0]          w_next;
        logic                      w_unused_hi;
        logic [WIDTH-1:0]          r_value;
        logic                      r_ovf;
        logic                      r_udf;

        assign w_en   = reinit[i] | incr_valid[i] | decr_valid[i];
        assign w_base = reinit[i] ? initial_value[i*WIDTH +: WIDTH] : r_value;
        assign w_inc  = incr_valid[i] ? incr[i*STEP_W +: STEP_W] : '0;
        assign w_dec  = decr_valid[i] ? decr[i*STEP_W +: STEP_W] : '0;

        // All operands are zero-extended into the signed raw width, so the
        // sum cannot overflow the raw width for any legal parameter set.
        assign w_raw = $signed({2'b00, w_base})
                     + $signed({c_step_pad, w_inc})
                     - $signed({c_step_pad, w_dec});

        // Underflow and overflow are mutually exclusive: a negative raw
        // value can never exceed MAX_VALUE.
        assign w_udf = w_raw[c_raw_w-1];
        assign w_ovf = (w_raw > c_max_raw);

        // Wrap mode applies a single modulus correction; the step width is
        // assumed small enough that one correction always lands in range.
        always_comb begin
            w_sel = w_raw;
            if (w_ovf) begin
                w_sel = sat_mode[i] ? c_max_raw : (w_raw - c_mod_raw);
            end else if (w_udf) begin
                w_sel = sat_mode[i] ? '0 : (w_raw + c_mod_raw);
            end
        end

        assign w_next      = w_en ? w_sel[WIDTH-1:0] : r_value;
        assign w_unused_hi = &{1'b0, w_sel[c_raw_w-1:WIDTH]};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_value <= c_reset_w;
            end else if (w_en) begin
                r_value <= w_next;
            end
        end

        // A new event in the same cycle takes priority over a clear so that
        // no overflow/underflow is ever lost.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (w_en && w_ovf) begin
                    r_ovf <= 1'b1;
                end else if (clr_flags[i]) begin
                    r_ovf <= 1'b0;
                end
                if (w_en && w_udf) begin
                    r_udf <= 1'b1;
                end else if (clr_flags[i]) begin
                    r_udf <= 1'b0;
                end
            end
        end

        assign value[i*WIDTH +: WIDTH]      = r_value;
        assign value_next[i*WIDTH +: WIDTH] = w_next;
        assign at_zero[i]                   = (r_value == '0);
        assign at_max[i]                    = (r_value == c_max_w);
        assign ovf_sticky[i]                = r_ovf;
        assign udf_sticky[i]                = r_udf;
    end : g_ch

endmodule : counter_bank
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_bank
// Description : Self-checking bench for counter_bank. Two instances share the
//               same stimulus: one with the full 8-bit range (MAX 255) and one
//               with MAX 200, compared against an integer reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_bank;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int S     = 2;
    localparam int MAX_W = 255;
    localparam int MAX_S = 200;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   sat_mode;
    logic [N-1:0]   reinit;
    logic [N*W-1:0] initial_value;
    logic [N-1:0]   incr_valid;
    logic [N*S-1:0] incr;
    logic [N-1:0]   decr_valid;
    logic [N*S-1:0] decr;
    logic [N-1:0]   clr_flags;

    logic [N*W-1:0] val_w, vn_w, val_s, vn_s;
    logic [N-1:0]   az_w, am_w, ovf_w, udf_w;
    logic [N-1:0]   az_s, am_s, ovf_s, udf_s;

    counter_bank #(.NUM_CH(N), .WIDTH(W), .STEP_W(S)) dut_w (
        .clk(clk), .rst_n(rst_n), .sat_mode(sat_mode), .reinit(reinit),
        .initial_value(initial_value), .incr_valid(incr_valid), .incr(incr),
        .decr_valid(decr_valid), .decr(decr), .clr_flags(clr_flags),
        .value(val_w), .value_next(vn_w), .at_zero(az_w), .at_max(am_w),
        .ovf_sticky(ovf_w), .udf_sticky(udf_w)
    );

    counter_bank #(.NUM_CH(N), .WIDTH(W), .STEP_W(S), .MAX_VALUE(MAX_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .sat_mode(sat_mode), .reinit(reinit),
        .initial_value(initial_value), .incr_valid(incr_valid), .incr(incr),
        .decr_valid(decr_valid), .decr(decr), .clr_flags(clr_flags),
        .value(val_s), .value_next(vn_s), .at_zero(az_s), .at_max(am_s),
        .ovf_sticky(ovf_s), .udf_sticky(udf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: one integer count and two flags per channel.
    int mv_w[N];
    int mv_s[N];
    bit mo_w[N], mu_w[N], mo_s[N], mu_s[N];

    // Next count from the arithmetic rules, evaluated on the current inputs.
    function automatic int model_next(input int cur, input int c, input int mx,
                                      output bit o, output bit u);
        int base, inc, dec, raw;
        o = 1'b0;
        u = 1'b0;
        if (!(reinit[c] || incr_valid[c] || decr_valid[c])) return cur;
        base = reinit[c] ? int'(initial_value[c*W +: W]) : cur;
        inc  = incr_valid[c] ? int'(incr[c*S +: S]) : 0;
        dec  = decr_valid[c] ? int'(decr[c*S +: S]) : 0;
        raw  = base + inc - dec;
        if (raw > mx) begin
            o = 1'b1;
            return sat_mode[c] ? mx : raw - (mx + 1);
        end
        if (raw < 0) begin
            u = 1'b1;
            return sat_mode[c] ? 0 : raw + (mx + 1);
        end
        return raw;
    endfunction

    function automatic int chv(input logic [N*W-1:0] bus, input int c);
        return int'(bus[c*W +: W]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            mv_w[c] = 0; mv_s[c] = 0;
            mo_w[c] = 0; mu_w[c] = 0; mo_s[c] = 0; mu_s[c] = 0;
        end
    endtask

    task automatic idle();
        sat_mode = '0; reinit = '0; initial_value = '0;
        incr_valid = '0; incr = '0; decr_valid = '0; decr = '0; clr_flags = '0;
    endtask

    // Advance one clock edge and the model with it; leaves time at edge + 1.
    task automatic tick();
        int nw[N];
        int ns[N];
        bit o, u;
        for (int c = 0; c < N; c++) begin
            nw[c] = model_next(mv_w[c], c, MAX_W, o, u);
            if (o) mo_w[c] = 1; else if (clr_flags[c]) mo_w[c] = 0;
            if (u) mu_w[c] = 1; else if (clr_flags[c]) mu_w[c] = 0;
            ns[c] = model_next(mv_s[c], c, MAX_S, o, u);
            if (o) mo_s[c] = 1; else if (clr_flags[c]) mo_s[c] = 0;
            if (u) mu_s[c] = 1; else if (clr_flags[c]) mu_s[c] = 0;
        end
        @(posedge clk);
        for (int c = 0; c < N; c++) begin
            mv_w[c] = nw[c];
            mv_s[c] = ns[c];
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < N; c++) begin
            checks++;
            if (chv(val_w, c) !== 0 || ovf_w[c] !== 1'b0 || udf_w[c] !== 1'b0 ||
                az_w[c] !== 1'b1 || am_w[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_w ch%0d: value=%0d ovf=%b udf=%b az=%b am=%b, need 0 0 0 1 0",
                         c, chv(val_w, c), ovf_w[c], udf_w[c], az_w[c], am_w[c]);
            end
            checks++;
            if (chv(val_s, c) !== 0 || ovf_s[c] !== 1'b0 || udf_s[c] !== 1'b0 ||
                az_s[c] !== 1'b1 || am_s[c] !== 1'b0) begin
                errors++;
                $display("FAIL reset_s ch%0d: value=%0d ovf=%b udf=%b az=%b am=%b, need 0 0 0 1 0",
                         c, chv(val_s, c), ovf_s[c], udf_s[c], az_s[c], am_s[c]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Load a non-zero value, then pull reset between edges.
        reinit = '1;
        initial_value = {4{8'd77}};
        tick();
        idle();
        checks++;
        if (chv(val_w, 3) !== 77) begin
            errors++;
            $display("FAIL reinit_before_reset: value=%0d need 77", chv(val_w, 3));
        end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        for (int c = 0; c < N; c++) begin
            checks++;
            if (chv(val_w, c) !== 0 || chv(val_s, c) !== 0) begin
                errors++;
                $display("FAIL async_reset ch%0d: values %0d/%0d need 0",
                         c, chv(val_w, c), chv(val_s, c));
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        incr_valid = 4'b0001;
        incr = 8'h01;
        tick();
        idle();
        checks++;
        if (chv(val_w, 0) !== 1 || chv(val_w, 1) !== 0) begin
            errors++;
            $display("FAIL first_after_reset: ch0=%0d ch1=%0d need 1 0",
                     chv(val_w, 0), chv(val_w, 1));
        end
    endtask

    task automatic test_wrap();
        idle(); clr_flags = '1; tick(); idle();
        reinit[0] = 1'b1; initial_value[7:0] = 8'd254;
        tick(); idle();
        incr_valid[0] = 1'b1; incr[1:0] = 2'd3;
        #1;
        checks++;
        if (chv(vn_w, 0) !== 1) begin
            errors++;
            $display("FAIL wrap_value_next: got %0d need 1", chv(vn_w, 0));
        end
        tick(); idle();
        checks++;
        if (chv(val_w, 0) !== 1 || ovf_w[0] !== 1'b1 || udf_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf: value=%0d ovf=%b udf=%b need 1 1 0",
                     chv(val_w, 0), ovf_w[0], udf_w[0]);
        end
        decr_valid[0] = 1'b1; decr[1:0] = 2'd2;
        tick(); idle();
        checks++;
        if (chv(val_w, 0) !== 255 || udf_w[0] !== 1'b1 || am_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_udf: value=%0d udf=%b at_max=%b need 255 1 1",
                     chv(val_w, 0), udf_w[0], am_w[0]);
        end
    endtask

    task automatic test_saturate();
        idle(); clr_flags = '1; tick(); idle();
        sat_mode = '1; reinit[0] = 1'b1; initial_value[7:0] = 8'd199;
        tick(); idle(); sat_mode = '1;
        incr_valid[0] = 1'b1; incr[1:0] = 2'd3;
        tick(); idle(); sat_mode = '1;
        checks++;
        if (chv(val_s, 0) !== 200 || am_s[0] !== 1'b1 || ovf_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_ovf: value=%0d at_max=%b ovf=%b need 200 1 1",
                     chv(val_s, 0), am_s[0], ovf_s[0]);
        end
        reinit[0] = 1'b1; initial_value[7:0] = 8'd1;
        tick(); idle(); sat_mode = '1;
        decr_valid[0] = 1'b1; decr[1:0] = 2'd3;
        tick(); idle();
        checks++;
        if (chv(val_s, 0) !== 0 || az_s[0] !== 1'b1 || udf_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_udf: value=%0d at_zero=%b udf=%b need 0 1 1",
                     chv(val_s, 0), az_s[0], udf_s[0]);
        end
    endtask

    task automatic test_reinit_hold();
        idle();
        reinit[1] = 1'b1; initial_value[15:8] = 8'd10;
        incr_valid[1] = 1'b1; incr[3:2] = 2'd2;
        decr_valid[1] = 1'b1; decr[3:2] = 2'd1;
        tick(); idle();
        checks++;
        if (chv(val_w, 1) !== 11 || chv(val_s, 1) !== 11) begin
            errors++;
            $display("FAIL reinit_net: values %0d/%0d need 11", chv(val_w, 1), chv(val_s, 1));
        end
        #1;
        checks++;
        if (chv(vn_w, 1) !== 11 || chv(vn_s, 1) !== 11) begin
            errors++;
            $display("FAIL hold_value_next: %0d/%0d need 11", chv(vn_w, 1), chv(vn_s, 1));
        end
        tick();
        checks++;
        if (chv(val_w, 1) !== 11) begin
            errors++;
            $display("FAIL hold_value: got %0d need 11", chv(val_w, 1));
        end
    endtask

    task automatic test_flags();
        idle(); clr_flags = '1; tick(); idle();
        reinit[2] = 1'b1; initial_value[23:16] = 8'd255;
        incr_valid[2] = 1'b1; incr[5:4] = 2'd1;
        tick(); idle();
        checks++;
        if (ovf_w[2] !== 1'b1 || chv(val_w, 2) !== 0) begin
            errors++;
            $display("FAIL flag_set: ovf=%b value=%0d need 1 0", ovf_w[2], chv(val_w, 2));
        end
        reinit[2] = 1'b1; initial_value[23:16] = 8'd255;
        incr_valid[2] = 1'b1; incr[5:4] = 2'd2;
        clr_flags[2] = 1'b1;
        tick(); idle();
        checks++;
        if (ovf_w[2] !== 1'b1 || chv(val_w, 2) !== 1) begin
            errors++;
            $display("FAIL flag_set_beats_clr: ovf=%b value=%0d need 1 1", ovf_w[2], chv(val_w, 2));
        end
        clr_flags[2] = 1'b1;
        tick(); idle();
        checks++;
        if (ovf_w[2] !== 1'b0 || udf_w[2] !== 1'b0 || chv(val_w, 2) !== 1) begin
            errors++;
            $display("FAIL flag_clear: ovf=%b udf=%b value=%0d need 0 0 1",
                     ovf_w[2], udf_w[2], chv(val_w, 2));
        end
    endtask

    task automatic test_multi();
        idle();
        reinit = '1;
        initial_value = {8'd40, 8'd30, 8'd20, 8'd10};
        tick(); idle();
        incr_valid[0] = 1'b1; incr[1:0] = 2'd2;
        decr_valid[1] = 1'b1; decr[3:2] = 2'd3;
        reinit[2] = 1'b1; initial_value[23:16] = 8'd99;
        tick(); idle();
        checks++;
        if (chv(val_w, 0) !== 12 || chv(val_w, 1) !== 17 ||
            chv(val_w, 2) !== 99 || chv(val_w, 3) !== 40) begin
            errors++;
            $display("FAIL multi_channel: %0d %0d %0d %0d need 12 17 99 40",
                     chv(val_w, 0), chv(val_w, 1), chv(val_w, 2), chv(val_w, 3));
        end
    endtask

    task automatic test_random();
        bit o, u;
        int e;
        for (int n = 0; n < 400; n++) begin
            sat_mode   = 4'($urandom);
            incr_valid = 4'($urandom);
            decr_valid = 4'($urandom);
            incr       = 8'($urandom);
            decr       = 8'($urandom);
            for (int c = 0; c < N; c++) begin
                reinit[c]    = ($urandom_range(0, 7) == 0);
                clr_flags[c] = ($urandom_range(0, 7) == 0);
                initial_value[c*W +: W] = ($urandom_range(0, 1) == 0) ?
                    8'($urandom_range(0, 3)) : 8'($urandom_range(194, 255));
            end
            #1;
            for (int c = 0; c < N; c++) begin
                e = model_next(mv_w[c], c, MAX_W, o, u);
                checks++;
                if (chv(vn_w, c) !== e) begin
                    errors++;
                    $display("FAIL rand_next_w n%0d ch%0d: got %0d need %0d", n, c, chv(vn_w, c), e);
                end
                e = model_next(mv_s[c], c, MAX_S, o, u);
                checks++;
                if (chv(vn_s, c) !== e) begin
                    errors++;
                    $display("FAIL rand_next_s n%0d ch%0d: got %0d need %0d", n, c, chv(vn_s, c), e);
                end
            end
            tick();
            for (int c = 0; c < N; c++) begin
                checks++;
                if (chv(val_w, c) !== mv_w[c] || ovf_w[c] !== mo_w[c] || udf_w[c] !== mu_w[c] ||
                    az_w[c] !== (mv_w[c] == 0) || am_w[c] !== (mv_w[c] == MAX_W)) begin
                    errors++;
                    $display("FAIL rand_state_w n%0d ch%0d: v=%0d o=%b u=%b az=%b am=%b need v=%0d o=%b u=%b",
                             n, c, chv(val_w, c), ovf_w[c], udf_w[c], az_w[c], am_w[c],
                             mv_w[c], mo_w[c], mu_w[c]);
                end
                checks++;
                if (chv(val_s, c) !== mv_s[c] || ovf_s[c] !== mo_s[c] || udf_s[c] !== mu_s[c] ||
                    az_s[c] !== (mv_s[c] == 0) || am_s[c] !== (mv_s[c] == MAX_S)) begin
                    errors++;
                    $display("FAIL rand_state_s n%0d ch%0d: v=%0d o=%b u=%b az=%b am=%b need v=%0d o=%b u=%b",
                             n, c, chv(val_s, c), ovf_s[c], udf_s[c], az_s[c], am_s[c],
                             mv_s[c], mo_s[c], mu_s[c]);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_saturate();
        test_reinit_hold();
        test_flags();
        test_multi();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_bank
`default_nettype wire
